hc_tx_port_arb: RTL and testbench

Responder end of the host controller's HCTxPort request/grant/ready/write interface. Arbitrates among three TX clients: port 0 direct line-state control, port 1 SOF sender, port 2 transaction sender. Grants one client at a time and paces its byte writes with a ready flag. Buffers each written cntl/data pair in a single-entry holding register and forwards it to the serial interface engine transmitter.

---
 rtl/hc_tx_port_arb_pkg.sv | 35 +++
 rtl/hc_tx_port_arb_if.sv | 31 +++
 rtl/hc_tx_port_arb_tx_hold_reg.sv | 41 ++++
 rtl/hc_tx_port_arb.sv | 127 ++++++++++++
 tb/tb_hc_tx_port_arb.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/hc_tx_port_arb_pkg.sv
// Shared definitions for the HCTxPort arbiter slice: SIE transmit control
// codes and small helpers for the owner index.
package hc_tx_port_arb_pkg;

    // SIE transmitter control codes, shared with the SIE transmitter.
    localparam logic [7:0] TX_DIRECT_CONTROL = 8'h00;
    localparam logic [7:0] TX_RESUME_START   = 8'h01;
    localparam logic [7:0] TX_PACKET_START   = 8'h02;
    localparam logic [7:0] TX_PACKET_STOP    = 8'h03;

    typedef logic [1:0] owner_t;

    // Fixed priority: port 0 beats port 1 beats port 2.
    function automatic owner_t lowestReq(input logic [2:0] reqVec);
        owner_t idx;
        idx = 2'd0;
        if (reqVec[0])      idx = 2'd0;
        else if (reqVec[1]) idx = 2'd1;
        else if (reqVec[2]) idx = 2'd2;
        return idx;
    endfunction

    function automatic logic [2:0] ownerOneHot(input owner_t idx);
        logic [2:0] vec;
        vec = 3'b000;
        case (idx)
            2'd0:    vec = 3'b001;
            2'd1:    vec = 3'b010;
            2'd2:    vec = 3'b100;
            default: vec = 3'b000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/hc_tx_port_arb_if.sv
// HCTxPort client request/grant/write bundle plus the SIE transmitter side.
interface hc_tx_port_arb_if;
    logic       req0, req1, req2;
    logic       wen0, wen1, wen2;
    logic [7:0] data0, data1, data2;
    logic [7:0] cntl0, cntl1, cntl2;
    logic       gnt0, gnt1, gnt2;
    logic       HCTxPortRdy;
    logic [7:0] SIETxCntl;
    logic [7:0] SIETxData;
    logic       SIETxWEn;
    logic       SIETxRdy;

    // Arbiter side.
    modport slave (
        input  req0, req1, req2, wen0, wen1, wen2,
        input  data0, data1, data2, cntl0, cntl1, cntl2,
        input  SIETxRdy,
        output gnt0, gnt1, gnt2, HCTxPortRdy,
        output SIETxCntl, SIETxData, SIETxWEn
    );

    // Client / SIE side.
    modport master (
        output req0, req1, req2, wen0, wen1, wen2,
        output data0, data1, data2, cntl0, cntl1, cntl2,
        output SIETxRdy,
        input  gnt0, gnt1, gnt2, HCTxPortRdy,
        input  SIETxCntl, SIETxData, SIETxWEn
    );
endinterface

// File: rtl/hc_tx_port_arb_tx_hold_reg.sv
// Single-entry holding register for one cntl/data pair, forwarded to the SIE
// transmitter as a one-cycle write strobe once the transmitter is ready.
module hc_tx_port_arb_tx_hold_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       accept,
    input  logic [7:0] cntlIn,
    input  logic [7:0] dataIn,
    input  logic       sieTxRdy,
    output logic       holdValid,
    output logic [7:0] sieTxCntl,
    output logic [7:0] sieTxData,
    output logic       sieTxWEn
);
    logic [7:0] holdCntl;
    logic [7:0] holdData;

    // Capture accepted writes and drain them to the SIE; strobe never repeats back-to-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdValid <= 1'b0;
            holdCntl  <= 8'h00;
            holdData  <= 8'h00;
            sieTxCntl <= 8'h00;
            sieTxData <= 8'h00;
            sieTxWEn  <= 1'b0;
        end else begin
            sieTxWEn <= 1'b0;
            if (accept) begin
                holdValid <= 1'b1;
                holdCntl  <= cntlIn;
                holdData  <= dataIn;
            end else if (holdValid && sieTxRdy && !sieTxWEn) begin
                sieTxCntl <= holdCntl;
                sieTxData <= holdData;
                sieTxWEn  <= 1'b1;
                holdValid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/hc_tx_port_arb.sv
// HCTxPort responder: fixed-priority, non-preemptive arbitration among three
// TX clients, ready pacing of the owner's writes, and hand-off of each byte
// to the holding register feeding the SIE transmitter.
module hc_tx_port_arb (
    input  logic             clk,
    input  logic             rst,
    hc_tx_port_arb_if.slave  bus
);
    import hc_tx_port_arb_pkg::*;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    arb_state_t state;
    owner_t     owner;
    logic [2:0] gnt;
    logic       rdy;

    logic [2:0] reqVec;
    logic       ownerReq;
    logic       ownerWen;
    logic [7:0] ownerData;
    logic [7:0] ownerCntl;
    logic       accept;
    logic       holdValid;
    logic [7:0] sieTxCntl;
    logic [7:0] sieTxData;
    logic       sieTxWEn;

    assign reqVec = {bus.req2, bus.req1, bus.req0};

    // Select the current owner's request, strobe and write payload.
    always_comb begin
        ownerReq  = 1'b0;
        ownerWen  = 1'b0;
        ownerData = 8'h00;
        ownerCntl = 8'h00;
        case (owner)
            2'd0: begin
                ownerReq  = bus.req0;
                ownerWen  = bus.wen0;
                ownerData = bus.data0;
                ownerCntl = bus.cntl0;
            end
            2'd1: begin
                ownerReq  = bus.req1;
                ownerWen  = bus.wen1;
                ownerData = bus.data1;
                ownerCntl = bus.cntl1;
            end
            2'd2: begin
                ownerReq  = bus.req2;
                ownerWen  = bus.wen2;
                ownerData = bus.data2;
                ownerCntl = bus.cntl2;
            end
            default: begin
                ownerReq  = 1'b0;
                ownerWen  = 1'b0;
                ownerData = 8'h00;
                ownerCntl = 8'h00;
            end
        endcase
    end

    // Non-owner strobes never reach this; a strobe into a full holding register is dropped.
    assign accept = (state == ARB_GRANT) && ownerWen && !holdValid;

    // Arbiter FSM with registered grants and ready. Ready is held low while a
    // byte is accepted or still held, so it returns the edge after the hold clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
            owner <= 2'd0;
            gnt   <= 3'b000;
            rdy   <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    rdy <= 1'b0;
                    if (|reqVec) begin
                        state <= ARB_GRANT;
                        owner <= lowestReq(reqVec);
                        gnt   <= ownerOneHot(lowestReq(reqVec));
                    end
                end
                ARB_GRANT: begin
                    if (ownerReq) begin
                        rdy <= !holdValid && !accept;
                    end else begin
                        state <= ARB_IDLE;
                        gnt   <= 3'b000;
                        rdy   <= 1'b0;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    gnt   <= 3'b000;
                    rdy   <= 1'b0;
                end
            endcase
        end
    end

    hc_tx_port_arb_tx_hold_reg uHold (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .cntlIn    (ownerCntl),
        .dataIn    (ownerData),
        .sieTxRdy  (bus.SIETxRdy),
        .holdValid (holdValid),
        .sieTxCntl (sieTxCntl),
        .sieTxData (sieTxData),
        .sieTxWEn  (sieTxWEn)
    );

    assign bus.gnt0        = gnt[0];
    assign bus.gnt1        = gnt[1];
    assign bus.gnt2        = gnt[2];
    assign bus.HCTxPortRdy = rdy;
    assign bus.SIETxCntl   = sieTxCntl;
    assign bus.SIETxData   = sieTxData;
    assign bus.SIETxWEn    = sieTxWEn;
endmodule

// File: tb/tb_hc_tx_port_arb.sv
// Directed bench for hc_tx_port_arb; SIE writes are checked against a
// scoreboard of bytes expected to be forwarded.
module tb_hc_tx_port_arb;
    import hc_tx_port_arb_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [15:0] sb[$];

    hc_tx_port_arb_if bus();

    hc_tx_port_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, and score any SIE write.
    task automatic tick();
        logic [15:0] exp;
        @(posedge clk);
        #1;
        if (bus.SIETxWEn === 1'b1) begin
            chk("sie_wen_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                chk("sie_cntl", 32'(bus.SIETxCntl), 32'(exp[15:8]));
                chk("sie_data", 32'(bus.SIETxData), 32'(exp[7:0]));
            end
        end
    endtask

    task automatic chkResetOutputs(input string tag);
        chk({tag, "_gnt"}, 32'({bus.gnt2, bus.gnt1, bus.gnt0}), 32'd0);
        chk({tag, "_rdy"}, 32'(bus.HCTxPortRdy), 32'd0);
        chk({tag, "_wen"}, 32'(bus.SIETxWEn), 32'd0);
        chk({tag, "_cntl"}, 32'(bus.SIETxCntl), 32'd0);
        chk({tag, "_data"}, 32'(bus.SIETxData), 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.req0 = 0; bus.req1 = 0; bus.req2 = 0;
        bus.wen0 = 0; bus.wen1 = 0; bus.wen2 = 0;
        bus.data0 = 0; bus.data1 = 0; bus.data2 = 0;
        bus.cntl0 = 0; bus.cntl1 = 0; bus.cntl2 = 0;
        bus.SIETxRdy = 1'b1;

        // Reset state
        tick();
        tick();
        chkResetOutputs("reset");
        rst = 1'b0;
        tick();

        // Single client
        bus.req0 = 1'b1;
        tick();
        chk("single_gnt0", 32'(bus.gnt0), 32'd1);
        chk("single_gnt12", 32'({bus.gnt2, bus.gnt1}), 32'd0);
        chk("single_rdy_early", 32'(bus.HCTxPortRdy), 32'd0);
        tick();
        chk("single_rdy", 32'(bus.HCTxPortRdy), 32'd1);
        bus.cntl0 = TX_DIRECT_CONTROL; bus.data0 = 8'h02; bus.wen0 = 1'b1;
        sb.push_back({TX_DIRECT_CONTROL, 8'h02});
        tick();
        bus.wen0 = 1'b0;
        chk("single_rdy_after_w", 32'(bus.HCTxPortRdy), 32'd0);
        chk("single_wen_w", 32'(bus.SIETxWEn), 32'd0);
        tick();
        chk("single_wen_w1", 32'(bus.SIETxWEn), 32'd1);
        chk("single_rdy_w1", 32'(bus.HCTxPortRdy), 32'd0);
        tick();
        chk("single_rdy_w2", 32'(bus.HCTxPortRdy), 32'd1);
        chk("single_wen_pulse", 32'(bus.SIETxWEn), 32'd0);
        chk("single_data_hold", 32'(bus.SIETxData), 32'h02);
        bus.req0 = 1'b0;
        tick();
        chk("single_release_gnt", 32'(bus.gnt0), 32'd0);
        chk("single_release_rdy", 32'(bus.HCTxPortRdy), 32'd0);
        tick();

        // Priority and lock
        bus.req0 = 1'b1; bus.req2 = 1'b1;
        tick();
        chk("prio_gnt", 32'({bus.gnt2, bus.gnt1, bus.gnt0}), 32'b001);
        bus.req1 = 1'b1;
        tick();
        tick();
        chk("lock_gnt", 32'({bus.gnt2, bus.gnt1, bus.gnt0}), 32'b001);
        bus.req0 = 1'b0;
        tick();
        chk("lock_gap", 32'({bus.gnt2, bus.gnt1, bus.gnt0}), 32'b000);
        tick();
        chk("next_gnt1", 32'({bus.gnt2, bus.gnt1, bus.gnt0}), 32'b010);
        bus.req1 = 1'b0; bus.req2 = 1'b0;
        tick();
        chk("gnt1_release", 32'({bus.gnt2, bus.gnt1, bus.gnt0}), 32'b000);
        tick();

        // SIE stall
        bus.req0 = 1'b1;
        tick();
        tick();
        chk("stall_rdy_pre", 32'(bus.HCTxPortRdy), 32'd1);
        bus.SIETxRdy = 1'b0;
        bus.cntl0 = TX_PACKET_START; bus.data0 = 8'h5A; bus.wen0 = 1'b1;
        sb.push_back({TX_PACKET_START, 8'h5A});
        tick();
        bus.wen0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_wen", 32'(bus.SIETxWEn), 32'd0);
            chk("stall_rdy", 32'(bus.HCTxPortRdy), 32'd0);
        end
        bus.SIETxRdy = 1'b1;
        tick();
        chk("stall_release_wen", 32'(bus.SIETxWEn), 32'd1);
        chk("stall_release_rdy", 32'(bus.HCTxPortRdy), 32'd0);
        tick();
        chk("stall_single_pulse", 32'(bus.SIETxWEn), 32'd0);
        chk("stall_rdy_back", 32'(bus.HCTxPortRdy), 32'd1);

        // Protocol error: non-owner write
        bus.cntl2 = TX_PACKET_STOP; bus.data2 = 8'hAA; bus.wen2 = 1'b1;
        tick();
        bus.wen2 = 1'b0;
        chk("nonowner_rdy", 32'(bus.HCTxPortRdy), 32'd1);
        chk("nonowner_gnt2", 32'(bus.gnt2), 32'd0);
        tick();
        chk("nonowner_wen1", 32'(bus.SIETxWEn), 32'd0);
        tick();
        chk("nonowner_wen2", 32'(bus.SIETxWEn), 32'd0);

        // Protocol error: owner writes again while the byte is still held
        bus.cntl0 = TX_PACKET_STOP; bus.data0 = 8'h11; bus.wen0 = 1'b1;
        sb.push_back({TX_PACKET_STOP, 8'h11});
        tick();
        bus.data0 = 8'h22;
        tick();
        bus.wen0 = 1'b0;
        chk("dbl_first_wen", 32'(bus.SIETxWEn), 32'd1);
        tick();
        chk("dbl_no_second_a", 32'(bus.SIETxWEn), 32'd0);
        chk("dbl_rdy", 32'(bus.HCTxPortRdy), 32'd1);
        tick();
        chk("dbl_no_second_b", 32'(bus.SIETxWEn), 32'd0);
        chk("dbl_data_kept", 32'(bus.SIETxData), 32'h11);

        // Release with data pending
        bus.SIETxRdy = 1'b0;
        bus.cntl0 = TX_PACKET_START; bus.data0 = 8'h33; bus.wen0 = 1'b1;
        sb.push_back({TX_PACKET_START, 8'h33});
        tick();
        bus.wen0 = 1'b0;
        bus.req0 = 1'b0;
        tick();
        chk("pend_gnt", 32'(bus.gnt0), 32'd0);
        chk("pend_rdy", 32'(bus.HCTxPortRdy), 32'd0);
        chk("pend_wen_a", 32'(bus.SIETxWEn), 32'd0);
        tick();
        tick();
        chk("pend_wen_b", 32'(bus.SIETxWEn), 32'd0);
        bus.SIETxRdy = 1'b1;
        tick();
        chk("pend_forward", 32'(bus.SIETxWEn), 32'd1);
        tick();

        // Reset mid-burst with a held byte
        bus.req1 = 1'b1;
        tick();
        chk("mid_gnt1", 32'(bus.gnt1), 32'd1);
        tick();
        bus.SIETxRdy = 1'b0;
        bus.cntl1 = TX_PACKET_START; bus.data1 = 8'h44; bus.wen1 = 1'b1;
        tick();
        bus.wen1 = 1'b0;
        chk("mid_held_gnt1", 32'(bus.gnt1), 32'd1);
        chk("mid_held_rdy", 32'(bus.HCTxPortRdy), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chkResetOutputs("midreset");
        bus.req1 = 1'b0;
        bus.SIETxRdy = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midreset_no_wen", 32'(bus.SIETxWEn), 32'd0);
            chk("midreset_no_gnt", 32'(bus.gnt1), 32'd0);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
